// File: rtl/mul_ctrl_fsm.sv
// Control sequencer for the byte-sliced RV32M multiplier datapath (MUL/MULH/MULHSU/MULHU).
// Latency: the start edge leads to done_o five cycles later. Throughput is one operation every five cycles.
// Backpressure: none. start_i is taken only in IDLE or DONE and ignored while busy. abort_i flushes to IDLE.
//
// Ports:
//   clk_i, rst_ni         clock and asynchronous active-low reset
//   start_i, funct3_i     request valid and RV32M multiply variant (sampled together)
//   abort_i               synchronous flush back to IDLE; wins over start_i
//   busy_o, done_o        operation in flight / one-cycle result-valid pulse
//   reg_A_en_o, reg_B_en_o, mux_B_sel_o, rol_en_o   operand register controls
//   ac_clr_o, AC_en_o     accumulator clear / accumulate
//   signed_A_o, sig_ctrl_B_o                        operand sign-extension controls
//   shift_0_o..shift_3_o  per-lane partial-product shift, in units of 8 bits
//   upper_o               result word select (1 = high word)

module mul_ctrl_fsm (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [2:0] funct3_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       reg_A_en_o,
  output logic       reg_B_en_o,
  output logic       mux_B_sel_o,
  output logic       rol_en_o,
  output logic       ac_clr_o,
  output logic       AC_en_o,
  output logic       signed_A_o,
  output logic [3:0] sig_ctrl_B_o,
  output logic [2:0] shift_0_o,
  output logic [2:0] shift_1_o,
  output logic [2:0] shift_2_o,
  output logic [2:0] shift_3_o,
  output logic       upper_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Operation flags captured at the accepted start edge.
  logic upper_q;
  logic signed_a_q;
  logic signed_b_q;

  // Decoded flags for the request currently on funct3_i.
  logic upper_d;
  logic signed_a_d;
  logic signed_b_d;

  logic       accept;   // start cycle: the request is visible to the datapath this cycle
  logic       load_op;  // the request is actually taken on this edge
  logic       in_step;  // one of S0..S3
  logic [1:0] step;     // partial-product step index k

  // Lane i multiplies by original B byte j = (i - k) mod 4. Its product weight is
  // 8*(i + j) bits because A byte i is paired with B byte j.
  function automatic logic [2:0] lane_shift(input logic [1:0] lane, input logic [1:0] k);
    logic [1:0] j;
    j = lane - k;
    return {1'b0, lane} + {1'b0, j};
  endfunction

  // Decode. Encodings with funct3[2] set fall back to plain MUL (low word, unsigned flags).
  always_comb begin
    upper_d    = 1'b0;
    signed_a_d = 1'b0;
    signed_b_d = 1'b0;
    if (!funct3_i[2]) begin
      upper_d    = (funct3_i[1:0] != 2'b00);
      signed_a_d = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
      signed_b_d = (funct3_i[1:0] == 2'b01);
    end
  end

  assign accept  = ((state == IDLE) || (state == DONE)) && start_i;
  assign load_op = accept && !abort_i;

  // State register and latched operation flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      upper_q    <= 1'b0;
      signed_a_q <= 1'b0;
      signed_b_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_op) begin
        upper_q    <= upper_d;
        signed_a_q <= signed_a_d;
        signed_b_q <= signed_b_d;
      end
    end
  end

  // Next-state logic. The flush override is applied last so that it beats every other transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = S0;
      S0:      state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3:      state_nxt = DONE;
      DONE:    state_nxt = start_i ? S0 : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  // Step index. Outside the steps it stays 0, so the lane shifts rest at the S0 pattern (0,2,4,6).
  always_comb begin
    in_step = 1'b1;
    step    = 2'd0;
    unique case (state)
      S0:      step = 2'd0;
      S1:      step = 2'd1;
      S2:      step = 2'd2;
      S3:      step = 2'd3;
      default: in_step = 1'b0;
    endcase
  end

  // Control outputs. These depend only on state, the latched flags and start_i.
  always_comb begin
    busy_o       = in_step;
    done_o       = (state == DONE);
    reg_A_en_o   = 1'b0;
    reg_B_en_o   = 1'b0;
    mux_B_sel_o  = 1'b0;
    rol_en_o     = 1'b0;
    ac_clr_o     = 1'b0;
    AC_en_o      = 1'b0;
    signed_A_o   = 1'b0;
    sig_ctrl_B_o = 4'b0000;
    upper_o      = upper_q;
    shift_0_o    = lane_shift(2'd0, step);
    shift_1_o    = lane_shift(2'd1, step);
    shift_2_o    = lane_shift(2'd2, step);
    shift_3_o    = lane_shift(2'd3, step);

    if (accept) begin
      // Load both operands straight from the operand buses and clear the accumulator.
      reg_A_en_o  = 1'b1;
      reg_B_en_o  = 1'b1;
      mux_B_sel_o = 1'b0;
      rol_en_o    = 1'b0;
      ac_clr_o    = 1'b1;
    end

    if (in_step) begin
      AC_en_o    = 1'b1;
      signed_A_o = signed_a_q;
      // The top byte of B (j == 3) sits in lane (k + 3) mod 4 during step k.
      if (signed_b_q) sig_ctrl_B_o = 4'b0001 << (step + 2'd3);
      // Rotate B on the same edge that the accumulator captures. This keeps the next lane
      // alignment ready for the next step. The last step has no successor.
      if (step != 2'd3) begin
        reg_B_en_o  = 1'b1;
        mux_B_sel_o = 1'b1;
        rol_en_o    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl_fsm.sv
// Directed bench for mul_ctrl_fsm. The stimulus queues expected operations and a monitor checks them.
// Latency: not applicable. Each expected result names the cycle in which done_o must appear.
// Backpressure: not applicable. The monitor samples every negative clock edge.

module tb_mul_ctrl_fsm;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [2:0] funct3_i;
  logic       abort_i;
  logic       busy_o, done_o, reg_A_en_o, reg_B_en_o, mux_B_sel_o, rol_en_o;
  logic       ac_clr_o, AC_en_o, signed_A_o, upper_o;
  logic [3:0] sig_ctrl_B_o;
  logic [2:0] shift_0_o, shift_1_o, shift_2_o, shift_3_o;

  mul_ctrl_fsm dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .funct3_i     (funct3_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .reg_A_en_o   (reg_A_en_o),
    .reg_B_en_o   (reg_B_en_o),
    .mux_B_sel_o  (mux_B_sel_o),
    .rol_en_o     (rol_en_o),
    .ac_clr_o     (ac_clr_o),
    .AC_en_o      (AC_en_o),
    .signed_A_o   (signed_A_o),
    .sig_ctrl_B_o (sig_ctrl_B_o),
    .shift_0_o    (shift_0_o),
    .shift_1_o    (shift_1_o),
    .shift_2_o    (shift_2_o),
    .shift_3_o    (shift_3_o),
    .upper_o      (upper_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // Lane shift codes for steps S0..S3. These were computed by hand from shift_i = i + ((i - k) mod 4).
  localparam int SHIFT_TBL[4][4] = '{'{0, 2, 4, 6}, '{3, 1, 3, 5}, '{2, 4, 2, 4}, '{1, 3, 5, 3}};

  typedef struct {
    logic        upper;
    logic        sa;
    logic [15:0] sig;       // sig_ctrl_B per step: nibble k belongs to step Sk
    int          steps;     // number of step cycles expected before the op ends
    bit          aborted;   // op ends without done_o
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive a start for one cycle and queue the matching expectation.
  // On return the bench is in the first step cycle.
  task automatic issue(input logic [2:0] f, input logic up, input logic sa,
                       input logic [15:0] sig, input int steps, input bit aborted);
    exp_t e;
    e.upper    = up;
    e.sa       = sa;
    e.sig      = sig;
    e.steps    = steps;
    e.aborted  = aborted;
    e.done_cyc = cyc + 5;
    exp_q.push_back(e);
    start_i  = 1'b1;
    funct3_i = f;
    tick();
    start_i  = 1'b0;
    funct3_i = ~f;   // operands need only be valid in the start cycle
  endtask

  // ---------------- monitor ----------------
  int         step_n    = 0;
  logic       prev_busy = 1'b0;
  logic [3:0] sig_rec[4];
  logic       sa_rec[4];

  task automatic close_op(input bit with_done);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_op_end", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("op_end_kind_done", int'(with_done), int'(!e.aborted));
      chk("op_step_count", step_n, e.steps);
      if (with_done) begin
        chk("done_latency_cycle", cyc, e.done_cyc);
        chk("upper_at_done", int'(upper_o), int'(e.upper));
      end
      for (int i = 0; i < 4; i++) begin
        if (i < e.steps && i < step_n) begin
          chk($sformatf("sig_ctrl_B_S%0d", i), int'(sig_rec[i]), int'(e.sig[i*4 +: 4]));
          chk($sformatf("signed_A_S%0d", i), int'(sa_rec[i]), int'(e.sa));
        end
      end
    end
    step_n = 0;
  endtask

  always @(negedge clk_i) begin
    if (busy_o) begin
      if (step_n > 3) begin
        chk("step_overrun", step_n, 3);
      end else begin
        chk("ac_en_step", int'(AC_en_o), 1);
        chk("done_in_step", int'(done_o), 0);
        chk("reg_a_en_step", int'(reg_A_en_o), 0);
        chk("ac_clr_step", int'(ac_clr_o), 0);
        chk("reg_b_en_step", int'(reg_B_en_o), int'(step_n < 3));
        chk("mux_b_sel_step", int'(mux_B_sel_o), int'(step_n < 3));
        chk("rol_en_step", int'(rol_en_o), int'(step_n < 3));
        chk("shift0_step", int'(shift_0_o), SHIFT_TBL[step_n][0]);
        chk("shift1_step", int'(shift_1_o), SHIFT_TBL[step_n][1]);
        chk("shift2_step", int'(shift_2_o), SHIFT_TBL[step_n][2]);
        chk("shift3_step", int'(shift_3_o), SHIFT_TBL[step_n][3]);
        sig_rec[step_n] = sig_ctrl_B_o;
        sa_rec[step_n]  = signed_A_o;
      end
      step_n++;
    end else begin
      if (done_o)         close_op(1'b1);
      else if (prev_busy) close_op(1'b0);
      chk("ac_en_idle", int'(AC_en_o), 0);
      chk("sig_ctrl_idle", int'(sig_ctrl_B_o), 0);
      chk("shift1_idle", int'(shift_1_o), 2);
      chk("shift3_idle", int'(shift_3_o), 6);
      if (start_i) begin
        chk("reg_a_en_start", int'(reg_A_en_o), 1);
        chk("reg_b_en_start", int'(reg_B_en_o), 1);
        chk("ac_clr_start", int'(ac_clr_o), 1);
        chk("mux_b_sel_start", int'(mux_B_sel_o), 0);
        chk("rol_en_start", int'(rol_en_o), 0);
      end else begin
        chk("reg_a_en_idle", int'(reg_A_en_o), 0);
        chk("reg_b_en_idle", int'(reg_B_en_o), 0);
        chk("ac_clr_idle", int'(ac_clr_o), 0);
      end
    end
    prev_busy = busy_o;
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [2:0]  f;
    logic        up;
    logic        sa;
    logic [15:0] sig;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{f: 3'b000, up: 1'b0, sa: 1'b0, sig: 16'h0000};  // MUL
    vecs[1] = '{f: 3'b001, up: 1'b1, sa: 1'b1, sig: 16'h4218};  // MULH: 8,1,2,4
    vecs[2] = '{f: 3'b010, up: 1'b1, sa: 1'b1, sig: 16'h0000};  // MULHSU
    vecs[3] = '{f: 3'b011, up: 1'b1, sa: 1'b0, sig: 16'h0000};  // MULHU
    vecs[4] = '{f: 3'b111, up: 1'b0, sa: 1'b0, sig: 16'h0000};  // unknown encoding behaves as MUL

    rst_ni   = 1'b0;
    start_i  = 1'b0;
    funct3_i = 3'b000;
    abort_i  = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_upper", int'(upper_o), 0);
    chk("rst_shift0", int'(shift_0_o), 0);
    chk("rst_shift2", int'(shift_2_o), 4);
    rst_ni = 1'b1;
    repeat (20) tick();
    chk("idle_busy", int'(busy_o), 0);

    // Each multiply variant in turn, with the bus idle between operations.
    foreach (vecs[v]) begin
      issue(vecs[v].f, vecs[v].up, vecs[v].sa, vecs[v].sig, 4, 1'b0);
      repeat (6) tick();
    end

    // upper_o keeps the high-word select after DONE.
    issue(3'b001, 1'b1, 1'b1, 16'h4218, 4, 1'b0);
    repeat (8) tick();
    chk("upper_hold_after_done", int'(upper_o), 1);

    // Back-to-back: a start in the DONE cycle gives a second done five cycles later.
    issue(3'b000, 1'b0, 1'b0, 16'h0000, 4, 1'b0);
    repeat (4) tick();
    chk("b2b_in_done", int'(done_o), 1);
    issue(3'b011, 1'b1, 1'b0, 16'h0000, 4, 1'b0);
    repeat (6) tick();

    // A start held high through S1 must not launch another operation.
    issue(3'b010, 1'b1, 1'b1, 16'h0000, 4, 1'b0);
    start_i = 1'b1;
    repeat (2) tick();
    start_i = 1'b0;
    repeat (8) tick();

    // An abort in S2 returns to IDLE on the next edge with no done_o.
    issue(3'b001, 1'b1, 1'b1, 16'h4218, 3, 1'b1);
    repeat (2) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_ac_en", int'(AC_en_o), 0);
    chk("abort_done", int'(done_o), 0);
    repeat (8) tick();

    // Asserting reset in S1 clears the state and flags at once.
    issue(3'b001, 1'b1, 1'b1, 16'h4218, 1, 1'b1);
    tick();
    rst_ni = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_upper", int'(upper_o), 0);
    chk("midrst_ac_en", int'(AC_en_o), 0);
    chk("midrst_sig", int'(sig_ctrl_B_o), 0);
    chk("midrst_shift1", int'(shift_1_o), 2);
    tick();
    rst_ni = 1'b1;
    repeat (8) tick();

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_ctrl_fsm.md
Name: mul_ctrl_fsm

Overview:
- Control FSM for the byte-sliced RV32M multiplier datapath.
- Accepts one multiply request (MUL/MULH/MULHSU/MULHU) per start handshake.
- Drives the datapath's operand-register enables, B-mux/rotate, sign controls, per-lane shift codes and accumulator enable. Sequences the four partial-product steps and signals completion.
- Sits between the execute-stage issue logic and the datapath.

Parameters:
- none

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  request valid; sampled only in IDLE or DONE.
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; sampled with start_i. Other values are treated as MUL.
- abort_i  in  1  synchronous flush; returns the FSM to IDLE.
- busy_o  out  1  high in S0..S3.
- done_o  out  1  one-cycle pulse; the datapath result is valid this cycle.
- reg_A_en_o  out  1  operand A register enable.
- reg_B_en_o  out  1  operand B register enable.
- mux_B_sel_o  out  1  0 = load op_B, 1 = recirculate reg_B.
- rol_en_o  out  1  rotate B left by 8 on load.
- ac_clr_o  out  1  synchronous accumulator clear.
- AC_en_o  out  1  accumulate partial result.
- signed_A_o  out  1  sign-extend top byte of A.
- sig_ctrl_B_o  out  4  per-lane sign-extend of the B byte.
- shift_0_o, shift_1_o, shift_2_o, shift_3_o  out  3 each  lane shift codes, in units of 8 bits.
- upper_o  out  1  result select; 1 = high word.

Behaviour:
- States: IDLE, S0, S1, S2, S3, DONE. State register and upper_o/signed_A/signed_B flops are cleared asynchronously when rst_ni=0.
- Reset values: state=IDLE, upper_o=0, all enables/clears/done/busy 0, sig_ctrl_B_o=0, shifts at idle defaults (0,2,4,6).
- Start (IDLE, or DONE with start_i=1), combinationally in that cycle:
  - reg_A_en=1, reg_B_en=1, mux_B_sel=0, rol_en=0, ac_clr=1.
  - On the edge, latch upper_o = (funct3!=000), signed_A = (funct3 is 001 or 010), signed_B = (funct3==001).
  - Next state S0.
- Step Sk (k=0..3):
  - AC_en=1.
  - Lane i holds original B byte j=(i-k) mod 4; shift_i = i+j.
  - S0 shifts (0,2,4,6); S1 (3,1,3,5); S2 (2,4,2,4); S3 (1,3,5,3).
  - sig_ctrl_B bit i = signed_B AND (j==3): S0 0b1000, S1 0b0001, S2 0b0010, S3 0b0100.
  - S0–S2: reg_B_en=1, mux_B_sel=1, rol_en=1, so B rotates for the next step on the same edge that the accumulator captures.
  - S3: reg_B_en=0, rol_en=0.
  - signed_A_o is held from the latch throughout S0..S3.
- DONE: done_o=1 for one cycle; upper_o holds; next state IDLE unless start_i=1 (back-to-back accepted).
- Latency: start edge to done_o = 5 cycles. Throughput: one operation per 5 cycles.
- start_i in S0..S3 is ignored; operands need only be valid in the start cycle.
- abort_i in any state forces IDLE on the next edge with no done_o. abort_i has priority over start_i.
- Outside S0..S3, AC_en=0. upper_o keeps its last value until the next accepted start, so the result stays readable after DONE.
- Reset mid-operation: immediate return to IDLE and reset values; no done_o.
- All control outputs are combinational from state, latched flags and start_i; no other combinational paths from inputs.

Test Plan:
- Reset then idle: rst_ni 0→1, no start → state IDLE, all enables 0, shifts 0/2/4/6, done_o never asserted for 20 cycles.
- MUL, start at cycle 0:
  - cycle 0: reg_A_en=reg_B_en=ac_clr=1.
  - cycles 1–4: AC_en=1, shifts per step (3,1,3,5 at cycle 2), sig_ctrl_B=0, signed_A=0.
  - cycle 5: done_o=1, upper_o=0.
- MULH: sig_ctrl_B sequence 8,1,2,4 over S0..S3; signed_A=1 for the whole operation; upper_o=1 at done.
- MULHSU: signed_A=1, sig_ctrl_B=0 in all steps, upper_o=1. MULHU: signed_A=0, sig_ctrl_B=0, upper_o=1.
- Back-to-back and ignored start:
  - start in the DONE cycle → done_o again exactly 5 cycles later.
  - start_i held high through S1 → no extra operation launched.
- abort_i asserted in S2 → IDLE next cycle, AC_en=0, no done_o. Same check with rst_ni pulsed low in S1 → IDLE and reset values immediately.
